// File: rtl/pixel_server.sv
// Double-buffered template (f) and search (g) pixel store for the disparity scan engine.
// The active bank is read with one cycle of latency while the shadow bank is loaded.
//
// state | meaning
// IDLE  | no valid frame yet, shadow bank loading
// SERVE | active bank valid, shadow bank accepting writes
// PEND  | active bank valid, shadow bank full, waiting for startsig to swap
module pixel_server #(
  parameter int PIX_W = 3,
  parameter int ROWS  = 16,
  parameter int COLS  = 79,
  parameter int XW    = 7,
  parameter int YW    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               wr_sel,
  input  logic [XW-1:0]      wr_x,
  input  logic [YW-1:0]      wr_y,
  input  logic [PIX_W-1:0]   wr_data,
  input  logic               wr_done,
  input  logic               startsig,
  input  logic [XW-1:0]      vector_xf,
  input  logic [XW-1:0]      vector_xg,
  input  logic [YW-1:0]      vector_y,
  output logic [PIX_W-1:0]   getfdata,
  output logic [2*PIX_W-1:0] get2f,
  output logic [PIX_W-1:0]   gdata,
  output logic               frame_valid,
  output logic               load_ready,
  output logic               wr_err
);

  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = $clog2(2 * DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PEND  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   act_bank;
  logic   swap;

  logic [PIX_W-1:0] mem_f [2*DEPTH];
  logic [PIX_W-1:0] mem_g [2*DEPTH];

  function automatic logic in_range(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return (int'(x) < COLS) && (int'(y) < ROWS);
  endfunction

  // Bank 1 occupies the upper half of each image array.
  function automatic logic [AW-1:0] lin(input logic bank, input logic [YW-1:0] y,
                                        input logic [XW-1:0] x);
    return (bank ? AW'(DEPTH) : '0) + AW'(y) * AW'(COLS) + AW'(x);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      act_bank <= 1'b0;
    end else begin
      state <= state_nxt;
      if (swap) act_bank <= ~act_bank;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wr_done)  state_nxt = SERVE;
      SERVE:   if (wr_done)  state_nxt = PEND;
      PEND:    if (startsig) state_nxt = SERVE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    frame_valid = (state != IDLE);
    load_ready  = (state != PEND);
    swap        = ((state == IDLE) && wr_done) || ((state == PEND) && startsig);
  end

  logic wr_ok;
  assign wr_ok = wr_en && load_ready && in_range(wr_x, wr_y);

  // Write uses the pre-swap bank select, so a write coinciding with wr_done lands in the new frame.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (wr_sel) mem_g[lin(~act_bank, wr_y, wr_x)] <= wr_data;
      else        mem_f[lin(~act_bank, wr_y, wr_x)] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err   <= 1'b0;
      getfdata <= '0;
      gdata    <= '0;
    end else begin
      wr_err   <= wr_en && !wr_ok;
      getfdata <= (frame_valid && in_range(vector_xf, vector_y))
                  ? mem_f[lin(act_bank, vector_y, vector_xf)] : '0;
      gdata    <= (frame_valid && in_range(vector_xg, vector_y))
                  ? mem_g[lin(act_bank, vector_y, vector_xg)] : '0;
    end
  end

  assign get2f = {{PIX_W{1'b0}}, getfdata} * {{PIX_W{1'b0}}, getfdata};

endmodule

// File: tb/tb_pixel_server.sv
// Randomized scoreboard bench for pixel_server against a bank/image reference model.
module tb_pixel_server;
  localparam int PIX_W = 3;
  localparam int ROWS  = 16;
  localparam int COLS  = 79;
  localparam int XW    = 7;
  localparam int YW    = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               wr_en = 1'b0, wr_sel = 1'b0, wr_done = 1'b0, startsig = 1'b0;
  logic [XW-1:0]      wr_x = '0, vector_xf = '0, vector_xg = '0;
  logic [YW-1:0]      wr_y = '0, vector_y = '0;
  logic [PIX_W-1:0]   wr_data = '0;
  logic [PIX_W-1:0]   getfdata, gdata;
  logic [2*PIX_W-1:0] get2f;
  logic               frame_valid, load_ready, wr_err;

  always #5 clk = ~clk;

  pixel_server #(.PIX_W(PIX_W), .ROWS(ROWS), .COLS(COLS), .XW(XW), .YW(YW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .wr_done(wr_done), .startsig(startsig),
    .vector_xf(vector_xf), .vector_xg(vector_xg), .vector_y(vector_y),
    .getfdata(getfdata), .get2f(get2f), .gdata(gdata),
    .frame_valid(frame_valid), .load_ready(load_ready), .wr_err(wr_err)
  );

  typedef struct {
    logic [7:0] f, f2, g;
    logic fv, lr, err;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   rand_rd = 1'b1;

  // Reference: two physical banks of f and g images, a mode (0 idle, 1 serve, 2 pend)
  // and the index of the bank currently being served.
  logic [2:0] mf [2][ROWS][COLS];
  logic [2:0] mg [2][ROWS][COLS];
  int m_mode = 0;
  int m_act  = 0;

  initial begin
    for (int b = 0; b < 2; b++)
      for (int y = 0; y < ROWS; y++)
        for (int x = 0; x < COLS; x++) begin
          mf[b][y][x] = '0;
          mg[b][y][x] = '0;
        end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, want, $time);
    end
  endtask

  task automatic step();
    exp_t e;
    bit   serving, accepting, ok;
    if (rand_rd) begin
      vector_xf = 7'($urandom_range(0, 84));
      vector_xg = 7'($urandom_range(0, 84));
      vector_y  = 4'($urandom_range(0, 15));
    end
    if (rst) begin
      e.f = 0; e.f2 = 0; e.g = 0; e.fv = 0; e.lr = 1; e.err = 0;
      m_mode = 0;
      m_act  = 0;
    end else begin
      serving   = (m_mode != 0);
      accepting = (m_mode != 2);
      e.f  = (serving && int'(vector_xf) < COLS) ? 8'(mf[m_act][vector_y][vector_xf]) : 8'd0;
      e.g  = (serving && int'(vector_xg) < COLS) ? 8'(mg[m_act][vector_y][vector_xg]) : 8'd0;
      e.f2 = e.f * e.f;
      ok   = accepting && int'(wr_x) < COLS && int'(wr_y) < ROWS;
      e.err = wr_en && !ok;
      if (wr_en && ok) begin
        if (wr_sel) mg[1-m_act][wr_y][wr_x] = wr_data;
        else        mf[1-m_act][wr_y][wr_x] = wr_data;
      end
      case (m_mode)
        0: if (wr_done) begin m_act = 1 - m_act; m_mode = 1; end
        1: if (wr_done) m_mode = 2;
        default: if (startsig) begin m_act = 1 - m_act; m_mode = 1; end
      endcase
      e.fv = (m_mode != 0);
      e.lr = (m_mode != 2);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    wr_en = 0; wr_done = 0; startsig = 0;
  endtask

  task automatic load_frame(input bit flat6);
    for (int s = 0; s < 2; s++)
      for (int y = 0; y < ROWS; y++)
        for (int x = 0; x < COLS; x++) begin
          wr_en   = 1;
          wr_sel  = s[0];
          wr_x    = 7'(x);
          wr_y    = 4'(y);
          wr_data = flat6 ? 3'd6 : 3'((x + y) % 8);
          wr_done = (s == 1 && y == ROWS - 1 && x == COLS - 1);
          step();
        end
  endtask

  task automatic rd(input int xf, input int xg, input int y);
    rand_rd   = 0;
    vector_xf = 7'(xf);
    vector_xg = 7'(xg);
    vector_y  = 4'(y);
    step();
    rand_rd   = 1;
  endtask

  task automatic bad_write(input int x, input int y);
    wr_en = 1; wr_sel = 0; wr_x = 7'(x); wr_y = 4'(y); wr_data = 3'd3;
    step();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() == 0) begin
        chk("sb_underflow", 8'd0, 8'd1);
      end else begin
        e = sb.pop_front();
        chk("getfdata", 8'(getfdata), e.f);
        chk("get2f", 8'(get2f), e.f2);
        chk("gdata", 8'(gdata), e.g);
        chk("frame_valid", 8'(frame_valid), 8'(e.fv));
        chk("load_ready", 8'(load_ready), 8'(e.lr));
        chk("wr_err", 8'(wr_err), 8'(e.err));
      end
    end
  end

  initial begin : driver
    rst = 1;
    repeat (3) step();
    rst = 0;
    repeat (4) step();

    load_frame(0);
    step();
    rd(5, 10, 3);
    rd(4, 4, 3);
    rd(79, 78, 3);
    rd(127, 79, 15);
    rd(0, 0, 0);

    load_frame(1);
    repeat (5) step();
    bad_write(1, 1);
    bad_write(100, 2);
    rd(4, 5, 3);
    startsig = 1;
    step();
    rd(1, 1, 1);
    rd(4, 10, 3);

    bad_write(100, 0);
    wr_done = 1; startsig = 1;
    step();
    repeat (3) step();
    startsig = 1;
    step();
    rd(1, 1, 1);
    repeat (3) step();

    wr_done = 1;
    step();
    repeat (2) step();
    rst = 1;
    step();
    rst = 0;
    repeat (3) step();
    load_frame(0);
    repeat (6) step();

    for (int i = 0; i < 3000; i++) begin
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_sel   = 1'($urandom_range(0, 1));
      wr_x     = 7'($urandom_range(0, 90));
      wr_y     = 4'($urandom_range(0, 15));
      wr_data  = 3'($urandom_range(0, 7));
      wr_done  = ($urandom_range(0, 199) == 0);
      startsig = ($urandom_range(0, 39) == 0);
      rst      = ($urandom_range(0, 1499) == 0);
      step();
      rst = 0;
    end
    repeat (4) step();

    #3;
    chk("sb_drained", 8'(sb.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
